regfile_debug_port: RTL
=======================

// Module: regfile_debug_port
// PURPOSE
//  Debug/bring-up engine driving register_file from the outside. DUMP mode walks a register
//  range on read_1 and streams each value out over a valid/ready port. LOAD mode accepts a
//  valid/ready word stream and writes consecutive registers via write/write_data/reg_write.
//  Sits beside the datapath's register_file; used by benches and the debug host.
// PARAMETERS
//  ADDR_W    5    register index width
//  DATA_W    32   register data width
// PORTS
//  clk         in   1       clock; all state changes on rising edge
//  reset       in   1       synchronous, active-high reset
//  start       in   1       begin operation; sampled in IDLE only
//  mode        in   1       0 = DUMP, 1 = LOAD; latched with start
//  first_reg   in   ADDR_W  first register of range; latched with start
//  last_reg    in   ADDR_W  last register of range, inclusive; latched with start
//  busy        out  1       high in every state except IDLE
//  done        out  1       one-cycle pulse at end of operation
//  out_data    out  DATA_W  DUMP word
//  out_valid   out  1       DUMP word valid
//  out_ready   in   1       sink accepts out_data
//  in_data     in   DATA_W  LOAD word
//  in_valid    in   1       LOAD word valid
//  in_ready    out  1       block accepts in_data
//  read_1      out  ADDR_W  to register_file read port 1
//  data_reg_1  in   DATA_W  from register_file read port 1 (combinational read)
//  write       out  ADDR_W  to register_file write address
//  write_data  out  DATA_W  to register_file write data
//  reg_write   out  1       to register_file write enable
// BEHAVIOUR
//  Reset: state IDLE; idx, busy, done, out_valid, out_data, in_ready, read_1, write,
//   write_data, reg_write all 0. Reset mid-operation aborts at once: held out word and
//   pending reg_write pulse discarded, no partial writes after reset.
//  FSM: IDLE, RD, SEND, WR, DONE. read_1 = idx (registered) in all states.
//  IDLE: start=1 -> latch mode/first/last, idx<=first_reg. first_reg>last_reg -> DONE
//   (empty range, no transfers); else DUMP -> RD, LOAD -> WR. start while busy ignored.
//  RD (1 cycle): out_data<=data_reg_1; -> SEND.
//  SEND: out_valid=1; out_data held stable until out_valid&out_ready. On handshake:
//   idx==last -> DONE else idx<=idx+1, -> RD. Throughput 1 word / 2 cycles.
//  WR: in_ready=1. On in_valid&in_ready: write<=idx, write_data<=in_data,
//   reg_write<=(idx!=0) for exactly one cycle (the cycle after accept); $0 never written,
//   its word is consumed. idx==last -> DONE else idx<=idx+1, stay WR.
//  DONE: done=1, busy=1, one cycle; -> IDLE. Final LOAD reg_write pulse coincides with DONE.
//  Range end compared before increment: last_reg=31 never wraps idx to 0.
//  out_valid and in_ready are never high together; reg_write never asserted in DUMP.
// STRUCTURE
//  Package regfile_dbg_pkg: ADDR_W/DATA_W constants, typedef enum {DUMP,LOAD} dbg_mode_t,
//   typedef enum {IDLE,RD,SEND,WR,DONE} dbg_state_t.
//  Single module; no sub-module. Bench instantiates register_file alongside and connects
//   read_1/data_reg_1/write/write_data/reg_write.
// TESTING
//  1 LOAD 5..7 with 0xA,0xB,0xC, in_valid held -> reg_write pulses write=5,6,7 with data
//    0xA,0xB,0xC; one done pulse; then DUMP 5..7 -> out_data 0xA,0xB,0xC in order.
//  2 DUMP 5..5 with out_ready=0 for 4 cycles -> out_valid held, out_data=0xA stable,
//    read_1=5 unchanged; accepted on first out_ready=1, done next cycle.
//  3 LOAD 0..1 with 0xF,0x5 -> no reg_write for idx 0, one pulse write=1 data 0x5;
//    DUMP 0..1 -> 0x0, 0x5.
//  4 first_reg=9, last_reg=3, start -> done pulse one cycle later; no out_valid, no reg_write.
//  5 DUMP 0..7, reset after 2nd handshake -> next cycle all outputs at reset values, IDLE;
//    new start DUMP 5..5 then returns 0xA.
//  6 DUMP 30..31 (preloaded 0x1E,0x1F) -> exactly 2 words, idx never 0; start pulsed while
//    busy ignored (no extra words, single done).

Source files
------------

// File: rtl/regfile_dbg_pkg.sv
// regfile_dbg_pkg: shared widths and enums for the register file debug port
package regfile_dbg_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  typedef enum logic {DUMP, LOAD} dbg_mode_t;
  typedef enum logic [2:0] {IDLE, RD, SEND, WR, DONE} dbg_state_t;
endpackage

// File: rtl/regfile_debug_port.sv
// regfile_debug_port: dumps or loads a register_file range over valid/ready streams
module regfile_debug_port
  import regfile_dbg_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] read_1,
  input  logic [DATA_W-1:0] data_reg_1,
  output logic [ADDR_W-1:0] write,
  output logic [DATA_W-1:0] write_data,
  output logic              reg_write
);
  dbg_state_t        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, last_q, last_d, write_q, write_d;
  logic [DATA_W-1:0] out_data_q, out_data_d, write_data_q, write_data_d;
  logic              reg_write_q, reg_write_d;
  // next state: the range end is compared before incrementing so idx never wraps
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    last_d       = last_q;
    out_data_d   = out_data_q;
    write_d      = write_q;
    write_data_d = write_data_q;
    reg_write_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        idx_d   = first_reg;
        last_d  = last_reg;
        state_d = first_reg > last_reg ? DONE : dbg_mode_t'(mode) == LOAD ? WR : RD;
      end
      RD: begin
        out_data_d = data_reg_1;
        state_d    = SEND;
      end
      SEND: if (out_ready) begin
        idx_d   = idx_q == last_q ? idx_q : idx_q + 1'b1;
        state_d = idx_q == last_q ? DONE : RD;
      end
      WR: if (in_valid) begin
        write_d      = idx_q;
        write_data_d = in_data;
        reg_write_d  = idx_q != '0;
        idx_d        = idx_q == last_q ? idx_q : idx_q + 1'b1;
        state_d      = idx_q == last_q ? DONE : WR;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset drops any held word and pending write pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      last_q       <= '0;
      out_data_q   <= '0;
      write_q      <= '0;
      write_data_q <= '0;
      reg_write_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      out_data_q   <= out_data_d;
      write_q      <= write_d;
      write_data_q <= write_data_d;
      reg_write_q  <= reg_write_d;
    end
  end
  assign busy       = state_q != IDLE;
  assign done       = state_q == DONE;
  assign out_valid  = state_q == SEND;
  assign in_ready   = state_q == WR;
  assign out_data   = out_data_q;
  assign read_1     = idx_q;
  assign write      = write_q;
  assign write_data = write_data_q;
  assign reg_write  = reg_write_q;
endmodule
